multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM that sequences the shared DataPath (PC, register file, ALU, unified memory) as a
//  multi-cycle MIPS-subset processor. Replaces per-instruction single-cycle control decode.
//  Decodes opcode/funct, drives all datapath enables and mux selects, and waits on memory
//  through a ready handshake. Counts retired instructions for the bench.
// PARAMETERS
//  WAIT_LIMIT  15  max consecutive cycles a memory state waits on memReady before memTimeout
//  CNT_W       32  width of retired-instruction counter
// PORTS
//  clock        in   1      single system clock, all state updates on posedge
//  reset        in   1      synchronous, active-high
//  opcode       in   6      instruction[31:26] from instruction register
//  funct        in   6      instruction[5:0]
//  zero         in   1      ALU zero flag
//  memReady     in   1      memory completes current read/write this cycle
//  pcWrite      out  1      load PC (includes beq&zero)
//  irWrite      out  1      load instruction register
//  iorD         out  1      0: mem addr = PC, 1: mem addr = ALUOut
//  memRead      out  1      memory read request
//  memWrite     out  1      memory write request
//  regWrite     out  1      register-file write enable
//  regDst       out  1      0: rt, 1: rd
//  memToReg     out  1      0: ALUOut, 1: MDR
//  ALUSrcA      out  1      0: PC, 1: rs
//  ALUSrcB      out  2      00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
//  aluControl   out  3      010 add, 110 sub, 000 and, 001 or, 111 slt
//  pcSource     out  2      00 ALU result, 01 ALUOut, 10 jump target, 11 trap vector
//  memTimeout   out  1      sticky: a memory wait exceeded WAIT_LIMIT
//  trap         out  1      illegal-instruction indication (see CONFIGURATION)
//  retired      out  CNT_W  instructions completed since reset
// BEHAVIOUR
//  - Reset, sampled on posedge: state<=FETCH, retired<=0, memTimeout<=0, wait counter<=0.
//    While reset is high, every control output is 0.
//  - Outputs are Moore decode of state; pcWrite and irWrite also depend on memReady and zero.
//    Unlisted outputs are 0; ALUSrcB and aluControl default to 00 and 010 (add).
//  - FETCH: memRead=1, iorD=0, ALUSrcA=0, ALUSrcB=01, pcSource=00.
//    irWrite=pcWrite=memReady. Hold in FETCH until memReady, then go to DECODE.
//  - DECODE: ALUSrcB=11 computes branch target into ALUOut. Next state by opcode:
//    0x23/0x2B->MEMADDR; 0x00->EXEC; 0x04->BRANCH; 0x08->ADDIEX; 0x02->JUMP; other->ILLEGAL.
//  - MEMADDR: ALUSrcA=1, ALUSrcB=10. Next MEMRD for lw, MEMWR for sw.
//  - MEMRD: memRead=1, iorD=1. Wait for memReady, then MEMWB.
//  - MEMWB: regWrite=1, memToReg=1, regDst=0. Retire, then FETCH.
//  - MEMWR: memWrite=1, iorD=1. Wait for memReady, then retire and go to FETCH.
//  - EXEC: ALUSrcA=1, ALUSrcB=00. funct 0x20/0x22/0x24/0x25/0x2A maps to add/sub/and/or/slt.
//    Any other funct is treated as ILLEGAL. Valid funct goes to RWB.
//  - RWB: regWrite=1, regDst=1. Retire, then FETCH.
//  - ADDIEX: ALUSrcA=1, ALUSrcB=10, add. Next ADDIWB: regWrite=1, regDst=0. Retire, then FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, sub, pcSource=01, pcWrite=zero. Retire, then FETCH.
//  - JUMP: pcSource=10, pcWrite=1. Retire, then FETCH.
//  - Retire: retired increments by 1 on exit from a retiring state. Wraps modulo 2^CNT_W.
//  - Memory wait counter:
//    - Clears on entry to FETCH/MEMRD/MEMWR and whenever memReady=1.
//    - Increments each waiting cycle, saturating at WAIT_LIMIT.
//    - When it reaches WAIT_LIMIT, memTimeout<=1 (sticky until reset). The FSM keeps waiting.
//  - memReady outside a memory state is ignored.
//  - Reset mid-instruction aborts it: no partial retire, and outputs are 0 in that cycle.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//    - ILLEGAL state: trap=1, pcSource=11, pcWrite=1 for one cycle, then FETCH. Not retired.
//  ILLEGAL_TRAP_EN undefined:
//    - ILLEGAL behaves as a NOP: one cycle with all outputs 0, retired+1, then FETCH.
//    - trap is tied 0.
// TESTING
//  1 add (op 0, funct 0x20), memReady=1 in FETCH
//    -> FETCH,DECODE,EXEC,RWB in 4 cycles; regWrite=1 and regDst=1 in RWB only; retired=1.
//  2 lw (0x23) with memReady low 3 cycles in MEMRD
//    -> memRead/iorD held 4 cycles; MEMWB regWrite=1, memToReg=1; total 8 cycles.
//  3 beq (0x04): zero=1 -> pcWrite=1 with pcSource=01 in BRANCH; zero=0 -> pcWrite=0.
//    Both cases: retired+1.
//  4 memReady held 0 in FETCH for 20 cycles (WAIT_LIMIT=15)
//    -> memTimeout=1 from the 15th wait cycle; state still FETCH.
//  5 opcode 0x3F: with ILLEGAL_TRAP_EN -> trap=1, pcSource=11, retired unchanged.
//    Without it -> all outputs 0, retired+1.
//  6 reset=1 during MEMWR -> next cycle FETCH, all outputs 0 while reset, retired=0, memTimeout=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the shared datapath (slave).
// The master drives the datapath enables and mux selects, and receives the decode fields and status.
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       memReady;
  logic       pcWrite;
  logic       irWrite;
  logic       iorD;
  logic       memRead;
  logic       memWrite;
  logic       regWrite;
  logic       regDst;
  logic       memToReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] aluControl;
  logic [1:0] pcSource;
  logic       memTimeout;
  logic       trap;

  modport master (
    input  opcode, funct, zero, memReady,
    output pcWrite, irWrite, iorD, memRead, memWrite, regWrite, regDst, memToReg,
           ALUSrcA, ALUSrcB, aluControl, pcSource, memTimeout, trap
  );

  modport slave (
    output opcode, funct, zero, memReady,
    input  pcWrite, irWrite, iorD, memRead, memWrite, regWrite, regDst, memToReg,
           ALUSrcA, ALUSrcB, aluControl, pcSource, memTimeout, trap
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute over a shared datapath,
// waits on memory via memReady, flags stuck memory (sticky memTimeout) and counts retirements.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal instructions redirect the PC to the trap
// vector instead of retiring as a NOP).
module multicycle_controller #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  multicycle_controller_if.master bus,
  output logic [CNT_W-1:0]       retired
);
  localparam int WCW = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADDR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_RWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_ILLEGAL
  } state_t;

  state_t           r_state, w_next;
  logic [WCW-1:0]   r_wcnt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_retired;

  logic       w_pcWrite, w_irWrite, w_iorD, w_memRead, w_memWrite, w_regWrite;
  logic       w_regDst, w_memToReg, w_ALUSrcA, w_trap, w_retire, w_wait;
  logic [1:0] w_ALUSrcB, w_pcSource;
  logic [2:0] w_aluControl;

  // Memory states stall while memReady is low; that is what the wait counter measures.
  assign w_wait = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                  && !bus.memReady;

  // State, wait counter, sticky timeout and retirement counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_wcnt    <= '0;
      r_timeout <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      // Any non-waiting cycle (memReady, or a non-memory state) leaves the counter at zero,
      // so every memory state is entered with a cleared count.
      if (!w_wait)
        r_wcnt <= '0;
      else if (r_wcnt != WCW'(WAIT_LIMIT))
        r_wcnt <= r_wcnt + WCW'(1);
      if (w_wait && (r_wcnt >= WCW'(WAIT_LIMIT - 1)))
        r_timeout <= 1'b1;
      if (w_retire)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Next-state and Moore control decode; pcWrite/irWrite also track memReady and zero.
  always_comb begin
    w_next       = r_state;
    w_pcWrite    = 1'b0;
    w_irWrite    = 1'b0;
    w_iorD       = 1'b0;
    w_memRead    = 1'b0;
    w_memWrite   = 1'b0;
    w_regWrite   = 1'b0;
    w_regDst     = 1'b0;
    w_memToReg   = 1'b0;
    w_ALUSrcA    = 1'b0;
    w_ALUSrcB    = 2'b00;
    w_aluControl = 3'b010;
    w_pcSource   = 2'b00;
    w_trap       = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memRead = 1'b1;
        w_ALUSrcB = 2'b01;
        w_irWrite = bus.memReady;
        w_pcWrite = bus.memReady;
        if (bus.memReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_ALUSrcB = 2'b11;
        case (bus.opcode)
          6'h23, 6'h2B: w_next = S_MEMADDR;
          6'h00:        w_next = S_EXEC;
          6'h04:        w_next = S_BRANCH;
          6'h08:        w_next = S_ADDIEX;
          6'h02:        w_next = S_JUMP;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADDR: begin
        w_ALUSrcA = 1'b1;
        w_ALUSrcB = 2'b10;
        w_next    = (bus.opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_memRead = 1'b1;
        w_iorD    = 1'b1;
        if (bus.memReady) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_regWrite = 1'b1;
        w_memToReg = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        w_memWrite = 1'b1;
        w_iorD     = 1'b1;
        if (bus.memReady) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_EXEC: begin
        w_ALUSrcA = 1'b1;
        w_next    = S_RWB;
        case (bus.funct)
          6'h20:   w_aluControl = 3'b010;
          6'h22:   w_aluControl = 3'b110;
          6'h24:   w_aluControl = 3'b000;
          6'h25:   w_aluControl = 3'b001;
          6'h2A:   w_aluControl = 3'b111;
          default: w_next       = S_ILLEGAL;
        endcase
      end
      S_RWB: begin
        w_regWrite = 1'b1;
        w_regDst   = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_ADDIEX: begin
        w_ALUSrcA = 1'b1;
        w_ALUSrcB = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regWrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        w_ALUSrcA    = 1'b1;
        w_aluControl = 3'b110;
        w_pcSource   = 2'b01;
        w_pcWrite    = bus.zero;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_JUMP: begin
        w_pcSource = 2'b10;
        w_pcWrite  = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL: begin
        w_trap     = 1'b1;
        w_pcSource = 2'b11;
        w_pcWrite  = 1'b1;
        w_next     = S_FETCH;
      end
`else
      S_ILLEGAL: begin
        // NOP: every control output low, including the ALU select.
        w_aluControl = 3'b000;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

  // Reset forces every output low in the cycle it is asserted, even mid-instruction.
  assign bus.pcWrite    = !reset && w_pcWrite;
  assign bus.irWrite    = !reset && w_irWrite;
  assign bus.iorD       = !reset && w_iorD;
  assign bus.memRead    = !reset && w_memRead;
  assign bus.memWrite   = !reset && w_memWrite;
  assign bus.regWrite   = !reset && w_regWrite;
  assign bus.regDst     = !reset && w_regDst;
  assign bus.memToReg   = !reset && w_memToReg;
  assign bus.ALUSrcA    = !reset && w_ALUSrcA;
  assign bus.ALUSrcB    = reset ? 2'b00 : w_ALUSrcB;
  assign bus.aluControl = reset ? 3'b000 : w_aluControl;
  assign bus.pcSource   = reset ? 2'b00 : w_pcSource;
  assign bus.trap       = !reset && w_trap;
  assign bus.memTimeout = !reset && r_timeout;
  assign retired        = reset ? '0 : r_retired;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through its state
// sequence, checking the packed control word each cycle plus retired and memTimeout.
module tb_multicycle_controller;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] retired;
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_ret  = 0;

  multicycle_controller_if bus ();
  multicycle_controller #(.WAIT_LIMIT(15), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .bus(bus), .retired(retired)
  );

  always #5 clock = ~clock;

  // Control word: {pcWrite,irWrite,iorD,memRead,memWrite,regWrite,regDst,memToReg,ALUSrcA}
  //               _ALUSrcB _aluControl _pcSource _trap
  logic [16:0] ctl;
  assign ctl = {bus.pcWrite, bus.irWrite, bus.iorD, bus.memRead, bus.memWrite, bus.regWrite,
                bus.regDst, bus.memToReg, bus.ALUSrcA, bus.ALUSrcB, bus.aluControl,
                bus.pcSource, bus.trap};

  localparam logic [16:0] C_ZERO    = 17'b000000000_00_000_00_0;
  localparam logic [16:0] C_FETCH_R = 17'b110100000_01_010_00_0;
  localparam logic [16:0] C_FETCH_W = 17'b000100000_01_010_00_0;
  localparam logic [16:0] C_DECODE  = 17'b000000000_11_010_00_0;
  localparam logic [16:0] C_ADD     = 17'b000000001_00_010_00_0;
  localparam logic [16:0] C_SLT     = 17'b000000001_00_111_00_0;
  localparam logic [16:0] C_RWB     = 17'b000001100_00_010_00_0;
  localparam logic [16:0] C_MEMADDR = 17'b000000001_10_010_00_0;
  localparam logic [16:0] C_MEMRD   = 17'b001100000_00_010_00_0;
  localparam logic [16:0] C_MEMWB   = 17'b000001010_00_010_00_0;
  localparam logic [16:0] C_MEMWR   = 17'b001010000_00_010_00_0;
  localparam logic [16:0] C_BEQ_T   = 17'b100000001_00_110_01_0;
  localparam logic [16:0] C_BEQ_N   = 17'b000000001_00_110_01_0;
  localparam logic [16:0] C_JUMP    = 17'b100000000_00_010_10_0;
  localparam logic [16:0] C_ADDIEX  = 17'b000000001_10_010_00_0;
  localparam logic [16:0] C_ADDIWB  = 17'b000001000_00_010_00_0;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [16:0] C_ILLEGAL = 17'b100000000_00_010_11_1;
  localparam int          ILL_RET   = 0;
`else
  localparam logic [16:0] C_ILLEGAL = 17'b000000000_00_000_00_0;
  localparam int          ILL_RET   = 1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the control word for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [16:0] exp);
    #1 chk(tag, {15'd0, ctl}, {15'd0, exp});
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1; bus.opcode = 6'h00; bus.funct = 6'h20; bus.zero = 1'b0; bus.memReady = 1'b1;
    #1 chk("reset_retired", retired, 32'd0);
    chk("reset_timeout", {31'd0, bus.memTimeout}, 32'd0);
    cyc("reset_ctl0", C_ZERO);
    cyc("reset_ctl1", C_ZERO);
    reset = 1'b0;

    // add
    cyc("add_fetch", C_FETCH_R); cyc("add_decode", C_DECODE);
    cyc("add_exec", C_ADD);      cyc("add_rwb", C_RWB);
    exp_ret++; chk("add_retired", retired, exp_ret);

    // slt
    bus.funct = 6'h2A;
    cyc("slt_fetch", C_FETCH_R); cyc("slt_decode", C_DECODE);
    cyc("slt_exec", C_SLT);      cyc("slt_rwb", C_RWB);
    exp_ret++; chk("slt_retired", retired, exp_ret);

    // lw with three stall cycles in MEMRD
    bus.opcode = 6'h23;
    cyc("lw_fetch", C_FETCH_R); cyc("lw_decode", C_DECODE); cyc("lw_memaddr", C_MEMADDR);
    bus.memReady = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", C_MEMRD);
    chk("lw_no_early_retire", retired, exp_ret);
    bus.memReady = 1'b1;
    cyc("lw_memrd_ready", C_MEMRD); cyc("lw_memwb", C_MEMWB);
    exp_ret++; chk("lw_retired", retired, exp_ret);

    // sw
    bus.opcode = 6'h2B;
    cyc("sw_fetch", C_FETCH_R); cyc("sw_decode", C_DECODE); cyc("sw_memaddr", C_MEMADDR);
    cyc("sw_memwr", C_MEMWR);
    exp_ret++; chk("sw_retired", retired, exp_ret);

    // beq taken / not taken
    bus.opcode = 6'h04; bus.zero = 1'b1;
    cyc("beq_t_fetch", C_FETCH_R); cyc("beq_t_decode", C_DECODE); cyc("beq_t_branch", C_BEQ_T);
    exp_ret++; chk("beq_t_retired", retired, exp_ret);
    bus.zero = 1'b0;
    cyc("beq_n_fetch", C_FETCH_R); cyc("beq_n_decode", C_DECODE); cyc("beq_n_branch", C_BEQ_N);
    exp_ret++; chk("beq_n_retired", retired, exp_ret);

    // j
    bus.opcode = 6'h02;
    cyc("j_fetch", C_FETCH_R); cyc("j_decode", C_DECODE); cyc("j_jump", C_JUMP);
    exp_ret++; chk("j_retired", retired, exp_ret);

    // addi
    bus.opcode = 6'h08;
    cyc("addi_fetch", C_FETCH_R); cyc("addi_decode", C_DECODE);
    cyc("addi_ex", C_ADDIEX);     cyc("addi_wb", C_ADDIWB);
    exp_ret++; chk("addi_retired", retired, exp_ret);

    // R-type with unknown funct falls into ILLEGAL after EXEC
    bus.opcode = 6'h00; bus.funct = 6'h3F;
    cyc("badfn_fetch", C_FETCH_R); cyc("badfn_decode", C_DECODE);
    cyc("badfn_exec", C_ADD);      cyc("badfn_illegal", C_ILLEGAL);
    exp_ret += ILL_RET; chk("badfn_retired", retired, exp_ret);

    // illegal opcode
    bus.opcode = 6'h3F;
    cyc("illop_fetch", C_FETCH_R); cyc("illop_decode", C_DECODE); cyc("illop_illegal", C_ILLEGAL);
    exp_ret += ILL_RET; chk("illop_retired", retired, exp_ret);

    // FETCH starved for 20 cycles: timeout appears once 15 wait cycles have elapsed
    bus.memReady = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc("timeout_fetch_hold", C_FETCH_W);
      chk("timeout_flag", {31'd0, bus.memTimeout}, (k >= 15) ? 32'd1 : 32'd0);
    end
    chk("timeout_no_retire", retired, exp_ret);

    // sw, then reset while stalled in MEMWR
    bus.opcode = 6'h2B; bus.memReady = 1'b1;
    cyc("rst_sw_fetch", C_FETCH_R); cyc("rst_sw_decode", C_DECODE);
    cyc("rst_sw_memaddr", C_MEMADDR);
    bus.memReady = 1'b0;
    cyc("rst_sw_memwr", C_MEMWR);
    chk("rst_sticky_timeout", {31'd0, bus.memTimeout}, 32'd1);
    reset = 1'b1;
    #1 chk("rst_mid_retired", retired, 32'd0);
    chk("rst_mid_timeout", {31'd0, bus.memTimeout}, 32'd0);
    cyc("rst_mid_ctl", C_ZERO);
    reset = 1'b0;
    #1 chk("rst_after_retired", retired, 32'd0);
    chk("rst_after_timeout", {31'd0, bus.memTimeout}, 32'd0);
    cyc("rst_after_fetch", C_FETCH_W);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
